dac_play_buffer: RTL

- Output-direction counterpart of the ADC capture path: the MCU writes waveform samples over the parallel bus into a back buffer and commits them.
- The block plays the front buffer out to a 12-bit DAC, one sample per dac_clk rising edge.
- Buffers swap only at a playback boundary, giving glitch-free waveform updates.
- Sits between the bus decoder (en/addr_en/rd_en/wr_en strobes) and the DAC pins.

---
 rtl/dac_buf_pkg.sv | 17 +
 rtl/dac_sample_ram.sv | 37 +++
 rtl/dac_play_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dac_buf_pkg.sv
// Shared types and address constants for the DAC playback buffer.
// Imported by the sample RAM and the top-level controller.
package dac_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  localparam logic [15:0] CTRL_ADDR = 16'h4000;
  localparam logic [15:0] LEN_ADDR  = 16'h4001;
  localparam logic [15:0] MODE_ADDR = 16'h4002;

  localparam logic [11:0] MIDSCALE  = 12'h800;

endpackage

// File: rtl/dac_sample_ram.sv
// Double-buffered sample store: the MCU writes the back bank while the
// player reads the front bank through a registered (1-clk) read port.
module dac_sample_ram
  import dac_buf_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_front_sel,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] r_bank0 [DEPTH];
  (* ram_style = "block" *) logic [WIDTH-1:0] r_bank1 [DEPTH];

  // Writes always land in the back bank, so the front bank is never disturbed.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_front_sel) r_bank0[i_wr_addr] <= i_wr_data;
      else             r_bank1[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      o_rd_data <= i_front_sel ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];
    end
  end

endmodule

// File: rtl/dac_play_buffer.sv
// Bus-written double-buffered waveform player feeding a 12-bit DAC.
// Bank swaps happen only at a buffer boundary so waveform updates are glitch-free.
module dac_play_buffer
  import dac_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_SIZE   = 1024,
  parameter int DAC_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  addr_en,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  dac_clk,
  output logic [DAC_WIDTH-1:0]  dac_data,
  output logic                  playing,
  output state_t                o_dbg_state
);

  localparam int AW = $clog2(BUF_SIZE);
  localparam int LW = AW + 1;

  // Bus handshake: a strobe is taken on any clk edge where en and the strobe
  // are both high; there is no back-pressure, every accepted strobe completes.

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_front_sel, r_pending, r_underrun, r_run, r_loop;
  logic                  r_played, r_paused, r_rise_defer, r_dac_clk_prev;
  logic [LW-1:0]         r_front_len, r_back_len;
  logic [AW-1:0]         r_rd_ptr;
  logic                  r_v1, r_v2;
  logic [DAC_WIDTH-1:0]  r_q_d;
  logic [DAC_WIDTH-1:0]  w_ram_q;

  logic w_bus_wr, w_bus_rd, w_sample_wr, w_ctrl_wr, w_len_wr, w_mode_wr;
  logic w_rise, w_rise_eff, w_last;
  logic w_do_swap, w_rd_issue, w_ptr_inc, w_ptr_clr, w_set_ur, w_set_pause, w_clr_pause;
  logic [LW-1:0]         w_len_in;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  assign w_bus_wr    = en & rd_en;
  assign w_bus_rd    = en & wr_en;
  assign w_sample_wr = w_bus_wr && (r_addr < DATA_WIDTH'(BUF_SIZE)) && !r_pending;
  assign w_ctrl_wr   = w_bus_wr && (r_addr == DATA_WIDTH'(CTRL_ADDR));
  assign w_len_wr    = w_bus_wr && (r_addr == DATA_WIDTH'(LEN_ADDR)) && !r_pending;
  assign w_mode_wr   = w_bus_wr && (r_addr == DATA_WIDTH'(MODE_ADDR));

  assign w_len_in = ((rd_data == '0) || (rd_data > DATA_WIDTH'(BUF_SIZE)))
                  ? LW'(BUF_SIZE) : rd_data[LW-1:0];

  always_comb begin
    w_rd_mux = '1;
    if (r_addr == DATA_WIDTH'(CTRL_ADDR))      w_rd_mux = DATA_WIDTH'({r_underrun, playing, r_pending});
    else if (r_addr == DATA_WIDTH'(LEN_ADDR))  w_rd_mux = DATA_WIDTH'(r_front_len);
    else if (r_addr == DATA_WIDTH'(MODE_ADDR)) w_rd_mux = DATA_WIDTH'({r_loop, r_run});
  end

  // A rise that lands in the SWAP cycle is replayed on the following clk.
  assign w_rise     = dac_clk & ~r_dac_clk_prev;
  assign w_rise_eff = w_rise | r_rise_defer;
  assign w_last     = ({1'b0, r_rd_ptr} == (r_front_len - LW'(1)));

  assign playing     = (r_state == ST_PLAY);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_swap   = 1'b0;
    w_rd_issue  = 1'b0;
    w_ptr_inc   = 1'b0;
    w_ptr_clr   = 1'b0;
    w_set_ur    = 1'b0;
    w_set_pause = 1'b0;
    w_clr_pause = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run && r_pending) begin
          w_state_nxt = ST_SWAP;
        end else if (r_run && r_paused) begin
          w_state_nxt = ST_PLAY;
          w_clr_pause = 1'b1;
        end else if (r_run && r_played && r_loop) begin
          w_state_nxt = ST_PLAY;
          w_ptr_clr   = 1'b1;
        end
      end
      ST_SWAP: begin
        w_do_swap   = 1'b1;
        w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (!r_run) begin
          w_state_nxt = ST_IDLE;
          w_set_pause = 1'b1;
        end else if (w_rise_eff) begin
          w_rd_issue = 1'b1;
          if (w_last) begin
            w_ptr_clr = 1'b1;
            if (r_pending) begin
              w_state_nxt = ST_SWAP;
            end else if (!r_loop) begin
              w_state_nxt = ST_IDLE;
              w_set_ur    = 1'b1;
            end
          end else begin
            w_ptr_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr         <= '0;
      wr_data        <= '1;
      r_front_sel    <= 1'b0;
      r_pending      <= 1'b0;
      r_underrun     <= 1'b0;
      r_run          <= 1'b0;
      r_loop         <= 1'b0;
      r_played       <= 1'b0;
      r_paused       <= 1'b0;
      r_rise_defer   <= 1'b0;
      r_dac_clk_prev <= 1'b0;
      r_front_len    <= LW'(BUF_SIZE);
      r_back_len     <= LW'(BUF_SIZE);
      r_rd_ptr       <= '0;
    end else begin
      r_dac_clk_prev <= dac_clk;
      r_rise_defer   <= (r_state == ST_SWAP) & w_rise;
      if (en && addr_en) r_addr  <= rd_data;
      if (w_bus_rd)      wr_data <= w_rd_mux;
      if (w_len_wr)      r_back_len <= w_len_in;
      if (w_mode_wr) begin
        r_run  <= rd_data[0];
        r_loop <= rd_data[1];
      end
      // A commit arriving in the swap cycle starts a fresh pending request.
      if (w_ctrl_wr && rd_data[0]) r_pending <= 1'b1;
      else if (w_do_swap)          r_pending <= 1'b0;
      if (w_set_ur)                     r_underrun <= 1'b1;
      else if (w_ctrl_wr && rd_data[1]) r_underrun <= 1'b0;
      if (r_state == ST_PLAY) r_played <= 1'b1;
      if (w_set_pause)                   r_paused <= 1'b1;
      else if (w_clr_pause || w_do_swap) r_paused <= 1'b0;
      if (w_do_swap) begin
        r_front_sel <= ~r_front_sel;
        r_front_len <= r_back_len;
      end
      if (w_do_swap || w_ptr_clr) r_rd_ptr <= '0;
      else if (w_ptr_inc)         r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Two-stage output pipeline: RAM read, then capture, then the DAC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_q_d    <= '0;
      dac_data <= DAC_WIDTH'(MIDSCALE);
    end else begin
      r_v1 <= w_rd_issue;
      r_v2 <= r_v1;
      if (r_v1) r_q_d    <= w_ram_q;
      if (r_v2) dac_data <= r_q_d;
    end
  end

  dac_sample_ram #(
    .DEPTH(BUF_SIZE),
    .WIDTH(DAC_WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk        (clk),
    .i_front_sel(r_front_sel),
    .i_wr_en    (w_sample_wr),
    .i_wr_addr  (r_addr[AW-1:0]),
    .i_wr_data  (rd_data[DAC_WIDTH-1:0]),
    .i_rd_en    (w_rd_issue),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_ram_q)
  );

endmodule
